// File: rtl/dmux_nway_stream.sv
// Registered 1-to-N stream demultiplexer with per-channel one-entry output buffers.
// Optional macro DMUX_ZERO_IDLE_EN forces idle channel outputs to zero.
module dmux_nway_stream #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned SEL_BITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in,
    input  logic [SEL_BITS-1:0]           z,
    input  logic                          bcast,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [(2**SEL_BITS)*WIDTH-1:0] out,
    output logic [(2**SEL_BITS)-1:0]      out_valid,
    input  logic [(2**SEL_BITS)-1:0]      out_ready
);

    localparam int unsigned N = 2 ** SEL_BITS;

    logic [N-1:0][WIDTH-1:0] data_q;
    logic [N-1:0]            valid_q;
    logic [N-1:0]            free;
    logic [N-1:0]            load;
    logic                    accept;

    // A channel can take a word if it is empty or its word leaves on this edge.
    assign free = ~valid_q | out_ready;

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = bcast ? (&free) : free[z];
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < int'(N); k++) begin
            load[k] = accept && (bcast || (int'(z) == k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                if (load[k]) begin
                    data_q[k]  <= in;
                    valid_q[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = valid_q;

    for (genvar k = 0; k < int'(N); k++) begin : g_out
`ifdef DMUX_ZERO_IDLE_EN
        assign out[k*WIDTH +: WIDTH] = data_q[k] & {WIDTH{valid_q[k]}};
`else
        assign out[k*WIDTH +: WIDTH] = data_q[k];
`endif
    end

endmodule

// File: tb/tb_dmux_nway_stream.sv
// Scoreboard bench for dmux_nway_stream: stimulus pushes expected words per channel,
// a negedge monitor pops them as each channel hands a word to its consumer.
module tb_dmux_nway_stream;

    localparam int W = 16;
    localparam int S = 3;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in;
    logic [S-1:0]   z;
    logic           bcast;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] out;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[N][$];

    always #5 clk = ~clk;

    dmux_nway_stream #(.WIDTH(W), .SEL_BITS(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .z         (z),
        .bcast     (bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [S-1:0] sel,
                         input logic b);
        in_valid = v;
        in       = d;
        z        = sel;
        bcast    = b;
    endtask

    // One clock cycle; exp_rdy < 0 skips the in_ready check.
    task automatic cyc(input int exp_rdy, input string name);
        @(negedge clk);
        if (exp_rdy >= 0) chk(name, {127'd0, in_ready}, exp_rdy[127:0]);
        if (rst) begin
            for (int k = 0; k < N; k++) exp_q[k].delete();
        end else if (in_valid && exp_rdy == 1) begin
            for (int k = 0; k < N; k++)
                if (bcast || int'(z) == k) exp_q[k].push_back(in);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handed-off word must be the oldest expected word on that channel.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < N; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected word ch%0d: got %h, expected none",
                                 k, out[k*W +: W]);
                    end else begin
                        chk($sformatf("deliver ch%0d", k), {112'd0, out[k*W +: W]},
                            {112'd0, exp_q[k].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        out_ready = '0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        // in_ready must read 0 while reset is held, even with everything free
        drive(1'b1, 16'h7777, 3'd1, 1'b1);
        out_ready = 8'hFF;
        cyc(0, "rdy in reset");
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        chk("reset out_valid", {120'd0, out_valid}, 128'd0);
        chk("reset out", out, 128'd0);

        // 1: single word to channel 3
        drive(1'b1, 16'hA5A5, 3'd3, 1'b0);
        cyc(1, "t1 rdy");
        drive(1'b0, '0, 3'd3, 1'b0);
        chk("t1 out_valid", {120'd0, out_valid}, 128'h08);
        chk("t1 data", {112'd0, out[63:48]}, 128'hA5A5);
        cyc(1, "t1 idle rdy");
        chk("t1 cleared", {120'd0, out_valid}, 128'd0);

        // 2: stalled channel 2, second word held then loaded on the drain edge
        out_ready = 8'hFB;
        drive(1'b1, 16'h1111, 3'd2, 1'b0);
        cyc(1, "t2 first rdy");
        drive(1'b1, 16'h2222, 3'd2, 1'b0);
        cyc(0, "t2 held a");
        cyc(0, "t2 held b");
        out_ready = 8'hFF;
        cyc(1, "t2 drain+load rdy");
        drive(1'b0, '0, '0, 1'b0);
        chk("t2 ch2 valid", {127'd0, out_valid[2]}, 128'd1);
        chk("t2 ch2 data", {112'd0, out[47:32]}, 128'h2222);
        cyc(-1, "");
        chk("t2 empty", {120'd0, out_valid}, 128'd0);

        // 3: stalled channel 5 does not block channel 6
        out_ready = 8'hDF;
        drive(1'b1, 16'h5A5A, 3'd5, 1'b0);
        cyc(1, "t3 ch5 rdy");
        drive(1'b1, 16'h0F0F, 3'd6, 1'b0);
        cyc(1, "t3 ch6 rdy");
        drive(1'b0, '0, '0, 1'b0);
        chk("t3 out_valid", {120'd0, out_valid}, 128'h60);
        chk("t3 ch5 data", {112'd0, out[95:80]}, 128'h5A5A);
        chk("t3 ch6 data", {112'd0, out[111:96]}, 128'h0F0F);
        cyc(-1, "");
        out_ready = 8'hFF;
        cyc(-1, "");
        chk("t3 empty", {120'd0, out_valid}, 128'd0);

        // 4: broadcast, then broadcast blocked by full channel 0
        drive(1'b1, 16'hBEEF, 3'd6, 1'b1);
        cyc(1, "t4 bcast rdy");
        chk("t4 out_valid", {120'd0, out_valid}, 128'hFF);
        chk("t4 data", out, {8{16'hBEEF}});
        out_ready = 8'hFE;
        drive(1'b1, 16'h1234, 3'd0, 1'b1);
        cyc(0, "t4 blocked a");
        cyc(0, "t4 blocked b");
        out_ready = 8'hFF;
        cyc(1, "t4 unblocked");
        drive(1'b0, '0, '0, 1'b0);
        chk("t4 out_valid 2", {120'd0, out_valid}, 128'hFF);
        chk("t4 data 2", out, {8{16'h1234}});
        cyc(-1, "");
        chk("t4 empty", {120'd0, out_valid}, 128'd0);

        // 5a: back-to-back stream, one accept per cycle, channel k gets k+1
        for (int k = 0; k < N; k++) begin
            drive(1'b1, W'(k + 1), S'(k), 1'b0);
            cyc(1, $sformatf("t5 stream rdy %0d", k));
        end
        drive(1'b0, '0, '0, 1'b0);
        chk("t5 last valid", {120'd0, out_valid}, 128'h80);
        cyc(-1, "");
        chk("t5 empty", {120'd0, out_valid}, 128'd0);

        // 5b: reset lands on the fifth word with four channels holding data
        out_ready = 8'h00;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, W'(16'h11 * (k + 1)), S'(k), 1'b0);
            cyc(1, $sformatf("t5b rdy %0d", k));
        end
        chk("t5b pre-reset valid", {120'd0, out_valid}, 128'h0F);
        drive(1'b1, 16'h0055, 3'd4, 1'b0);
        rst = 1'b1;
        cyc(0, "t5b rdy in reset");
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        chk("t5b reset valid", {120'd0, out_valid}, 128'd0);
        chk("t5b reset out", out, 128'd0);
        out_ready = 8'hFF;
        cyc(-1, "");
        chk("t5b no 5th word", {120'd0, out_valid}, 128'd0);

        // 6: idle output value after channel 4 drains
        drive(1'b1, 16'hC4C4, 3'd4, 1'b0);
        cyc(1, "t6 rdy");
        drive(1'b0, '0, '0, 1'b0);
        chk("t6 valid", {120'd0, out_valid}, 128'h10);
        chk("t6 data", {112'd0, out[79:64]}, 128'hC4C4);
        cyc(-1, "");
        chk("t6 drained", {120'd0, out_valid}, 128'd0);
`ifdef DMUX_ZERO_IDLE_EN
        chk("t6 idle ch4", {112'd0, out[79:64]}, 128'h0);
`else
        chk("t6 idle ch4", {112'd0, out[79:64]}, 128'hC4C4);
`endif
        chk("t6 idle ch3", {112'd0, out[63:48]}, 128'h0);

        for (int k = 0; k < N; k++)
            chk($sformatf("leftover ch%0d", k), 128'(exp_q[k].size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
